// File: rtl/iot_activity_monitor_if.sv
// ============================================================================
// Module      : iot_activity_monitor_if
// Description : Bus bundle between the device event decoders (master side)
//               and the activity monitor (slave side). It carries the
//               per-channel event strobes and directions, the synchronous
//               clear, and every status output the monitor returns to the
//               status/CSR block.
//   Signals   : clr         synchronous clear request
//               change      per-channel event strobe (N_CH)
//               on_off      per-channel direction, 1 = up (N_CH)
//               count_out   packed channel counters (N_CH*WIDTH)
//               total_out   registered sum of all counters (TW)
//               bound_flag  sticky per-channel wrap/clamp flag (N_CH)
//               alarm       hysteretic occupancy alarm
//               peak_out    running maximum of total_out (TW)
//   Modports  : master (event source / status reader), slave (monitor)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iot_activity_monitor_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned TW = WIDTH + $clog2(N_CH);

  logic                    clr;
  logic [N_CH-1:0]         change;
  logic [N_CH-1:0]         on_off;
  logic [N_CH*WIDTH-1:0]   count_out;
  logic [TW-1:0]           total_out;
  logic [N_CH-1:0]         bound_flag;
  logic                    alarm;
  logic [TW-1:0]           peak_out;

  modport master (
    output clr, change, on_off,
    input  count_out, total_out, bound_flag, alarm, peak_out
  );

  modport slave (
    input  clr, change, on_off,
    output count_out, total_out, bound_flag, alarm, peak_out
  );
endinterface

`default_nettype wire

// File: rtl/iot_activity_monitor.sv
// ============================================================================
// Module      : iot_activity_monitor
// Description : Multi-channel active-device monitor. One up/down counter per
//               device group (wrapping or saturating), a registered aggregate
//               total, a two-state hysteretic occupancy alarm driven by that
//               total, and sticky per-channel boundary flags.
//   Ports     : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    iot_activity_monitor_if.slave (clr, change, on_off in;
//                      count_out, total_out, bound_flag, alarm, peak_out out)
//   Options   : MONITOR_PEAK_EN - when defined, peak_out tracks the maximum
//               total_out since reset/clr; when undefined no peak logic is
//               built and peak_out is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iot_activity_monitor #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned ALARM_HI = 512,
  parameter int unsigned ALARM_LO = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  iot_activity_monitor_if.slave    bus
);

  // Total width: enough headroom that the sum of N_CH full-scale counters
  // can never overflow.
  localparam int unsigned      TW      = WIDTH + $clog2(N_CH);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_ALARM  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] cnt_q   [N_CH];
  logic [WIDTH-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  bound_q;
  logic [N_CH-1:0]  bound_d;
  logic [TW-1:0]    total_q;
  logic [TW-1:0]    total_d;
  state_t           state_q;
  state_t           state_d;
  logic [31:0]      total_ext;

  // --------------------------------------------------------------------------
  // Per-channel counter next-state. Channels are fully independent; a channel
  // whose strobe is low simply holds, so its flag can never be set by it.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      bound_d[i] = bound_q[i];
      if (bus.change[i]) begin
        if (bus.on_off[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            bound_d[i] = 1'b1;
            cnt_d[i]   = (SATURATE != 0) ? CNT_MAX : CNT_MIN;
          end else begin
            cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end else begin
          if (cnt_q[i] == CNT_MIN) begin
            bound_d[i] = 1'b1;
            cnt_d[i]   = (SATURATE != 0) ? CNT_MIN : CNT_MAX;
          end else begin
            cnt_d[i]   = cnt_q[i] - 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Aggregate: sums the registered counters, so total_out trails count_out
  // by exactly one edge. Each term is zero-extended to TW before adding.
  // --------------------------------------------------------------------------
  always_comb begin
    total_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      total_d = total_d + TW'(cnt_q[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Alarm FSM, evaluated on the registered total. Levels between ALARM_LO and
  // ALARM_HI hold the current state, giving the hysteresis band.
  // --------------------------------------------------------------------------
  assign total_ext = 32'(total_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (total_ext >= ALARM_HI) begin
          state_d = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (total_ext < ALARM_LO) begin
          state_d = ST_NORMAL;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers. clr outranks every strobe and wipes all state on the edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      bound_q <= '0;
      total_q <= '0;
      state_q <= ST_NORMAL;
    end else if (bus.clr) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      bound_q <= '0;
      total_q <= '0;
      state_q <= ST_NORMAL;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      bound_q <= bound_d;
      total_q <= total_d;
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional peak tracker: follows the registered total, so it trails
  // total_out by one edge.
  // --------------------------------------------------------------------------
`ifdef MONITOR_PEAK_EN
  logic [TW-1:0] peak_q;
  logic [TW-1:0] peak_d;

  always_comb begin
    peak_d = peak_q;
    if (total_q > peak_q) begin
      peak_d = total_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (bus.clr) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak_out = peak_q;
`else
  assign bus.peak_out = '0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign bus.count_out[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign bus.total_out  = total_q;
  assign bus.bound_flag = bound_q;
  assign bus.alarm      = (state_q == ST_ALARM);

endmodule

`default_nettype wire

// File: tb/tb_iot_activity_monitor.sv
// ============================================================================
// Module      : tb_iot_activity_monitor
// Description : Directed self-checking bench. Two monitors share clock and
//               reset: u_wrap (SATURATE=0) and u_sat (SATURATE=1), both with
//               N_CH=4, WIDTH=8, ALARM_HI=512, ALARM_LO=256. Expected values
//               are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iot_activity_monitor;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  iot_activity_monitor_if #(.N_CH(4), .WIDTH(8)) bw ();
  iot_activity_monitor_if #(.N_CH(4), .WIDTH(8)) bs ();

  iot_activity_monitor #(
    .N_CH(4), .WIDTH(8), .SATURATE(0), .ALARM_HI(512), .ALARM_LO(256)
  ) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw.slave)
  );

  iot_activity_monitor #(
    .N_CH(4), .WIDTH(8), .SATURATE(1), .ALARM_HI(512), .ALARM_LO(256)
  ) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drive both buses, take one rising edge, sample 1 ns later.
  task automatic step(input logic [3:0] cw, input logic [3:0] ow,
                      input logic [3:0] cs, input logic [3:0] os,
                      input logic clrv);
    bw.change = cw;
    bw.on_off = ow;
    bw.clr    = clrv;
    bs.change = cs;
    bs.on_off = os;
    bs.clr    = clrv;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
  endtask

  logic [31:0] peak_exp;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bw.change = '0; bw.on_off = '0; bw.clr = 1'b0;
    bs.change = '0; bs.on_off = '0; bs.clr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",  bw.count_out,  32'h0);
    check("rst_total",  32'(bw.total_out), 32'd0);
    check("rst_flag",   32'(bw.bound_flag), 32'd0);
    check("rst_alarm",  32'(bw.alarm), 32'd0);
    check("rst_peak",   32'(bw.peak_out), 32'd0);
    #4 rst_n = 1'b1;

    // Test 1: asynchronous reset mid-count, then restart
    step(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0);
    step(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0);
    check("t1_pre_count", bw.count_out, 32'd2);
    rst_n = 1'b0;
    #2;
    check("t1_async_count", bw.count_out, 32'd0);
    check("t1_async_total", 32'(bw.total_out), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0);
    check("t1_count3",     bw.count_out, 32'd3);
    check("t1_total_lag",  32'(bw.total_out), 32'd2);
    hold(1);
    check("t1_total3",     32'(bw.total_out), 32'd3);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b1);

    // Test 2: wrap on ch1, sticky flag, clr beats change
    for (int k = 0; k < 255; k++) step(4'b0010, 4'b0010, 4'b0, 4'b0, 1'b0);
    check("t2_ch1_255",  bw.count_out, 32'h0000_FF00);
    check("t2_flag_pre", 32'(bw.bound_flag), 32'd0);
    step(4'b0010, 4'b0010, 4'b0, 4'b0, 1'b0);
    check("t2_wrap_up",   bw.count_out, 32'h0);
    check("t2_flag_up",   32'(bw.bound_flag), 32'b0010);
    step(4'b0010, 4'b0000, 4'b0, 4'b0, 1'b0);
    check("t2_wrap_dn",   bw.count_out, 32'h0000_FF00);
    hold(2);
    check("t2_flag_sticky", 32'(bw.bound_flag), 32'b0010);
    step(4'b1111, 4'b1111, 4'b0, 4'b0, 1'b1);
    check("t2_clr_count", bw.count_out, 32'h0);
    check("t2_clr_flag",  32'(bw.bound_flag), 32'd0);
    check("t2_clr_total", 32'(bw.total_out), 32'd0);

    // Test 3: saturation on ch2 of u_sat
    for (int k = 0; k < 300; k++) step(4'b0, 4'b0, 4'b0100, 4'b0100, 1'b0);
    check("t3_sat_hi",    bs.count_out, 32'h00FF_0000);
    check("t3_flag_hi",   32'(bs.bound_flag), 32'b0100);
    for (int k = 0; k < 256; k++) step(4'b0, 4'b0, 4'b0100, 4'b0000, 1'b0);
    check("t3_sat_lo",    bs.count_out, 32'h0);
    check("t3_flag_lo",   32'(bs.bound_flag), 32'b0100);
    hold(1);
    check("t3_total0",    32'(bs.total_out), 32'd0);

    // Test 4: alarm hysteresis on u_wrap
    for (int k = 0; k < 128; k++) step(4'b1111, 4'b1111, 4'b0, 4'b0, 1'b0);
    check("t4_count128",  bw.count_out, 32'h8080_8080);
    check("t4_total508",  32'(bw.total_out), 32'd508);
    check("t4_alarm_off", 32'(bw.alarm), 32'd0);
    hold(1);
    check("t4_total512",  32'(bw.total_out), 32'd512);
    check("t4_alarm_lag", 32'(bw.alarm), 32'd0);
    hold(1);
    check("t4_alarm_on",  32'(bw.alarm), 32'd1);
    for (int k = 0; k < 53; k++) step(4'b1111, 4'b0000, 4'b0, 4'b0, 1'b0);
    hold(2);
    check("t4_total300",  32'(bw.total_out), 32'd300);
    check("t4_alarm300",  32'(bw.alarm), 32'd1);
    for (int k = 0; k < 11; k++) step(4'b1111, 4'b0000, 4'b0, 4'b0, 1'b0);
    hold(2);
    check("t4_total256",  32'(bw.total_out), 32'd256);
    check("t4_alarm256",  32'(bw.alarm), 32'd1);
    step(4'b0001, 4'b0000, 4'b0, 4'b0, 1'b0);
    hold(1);
    check("t4_total255",  32'(bw.total_out), 32'd255);
    check("t4_alarm_lag2", 32'(bw.alarm), 32'd1);
    hold(1);
    check("t4_alarm_clr", 32'(bw.alarm), 32'd0);
    check("t4_no_flag",   32'(bw.bound_flag), 32'd0);
`ifdef MONITOR_PEAK_EN
    peak_exp = 32'd512;
`else
    peak_exp = 32'd0;
`endif
    check("t4_peak",      32'(bw.peak_out), peak_exp);

    // Test 5: mixed same-cycle updates
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(4'b1111, 4'b1111, 4'b0, 4'b0, 1'b0);
    step(4'b1011, 4'b0001, 4'b0, 4'b0, 1'b0);
    check("t5_mixed",     bw.count_out, 32'h0405_0406);
    hold(1);
    check("t5_total19",   32'(bw.total_out), 32'd19);

    // Test 6: peak tracking
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
    check("t6_peak_clr0", 32'(bw.peak_out), 32'd0);
    for (int k = 0; k < 40; k++) step(4'b0001, 4'b0001, 4'b0, 4'b0, 1'b0);
    hold(2);
    for (int k = 0; k < 30; k++) step(4'b0001, 4'b0000, 4'b0, 4'b0, 1'b0);
    hold(2);
    check("t6_total10",   32'(bw.total_out), 32'd10);
`ifdef MONITOR_PEAK_EN
    peak_exp = 32'd40;
`else
    peak_exp = 32'd0;
`endif
    check("t6_peak40",    32'(bw.peak_out), peak_exp);
    step(4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
    check("t6_peak_clr",  32'(bw.peak_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
